// File: rtl/bit_scan_pkg.sv
// Shared types and helpers for the bit-scan encoder.
package bit_scan_pkg;

  // Encoder control states: nothing held, non-zero vector held, all-zero vector held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ZERO = 2'd2
  } bs_state_e;

  // Index width for a vector of vect_w bits (at least one bit).
  function automatic int unsigned idx_width(input int unsigned vect_w);
    if (vect_w < 2) begin
      return 1;
    end
    return $clog2(vect_w);
  endfunction

endpackage

// File: rtl/bit_scan_encoder_prio_enc.sv
// Combinational priority encoder: picks the first set bit in scan order and
// flags when exactly one bit remains set.
module prio_enc
  import bit_scan_pkg::*;
#(
  parameter int unsigned VECT_W    = 8,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned IDX_W    = idx_width(VECT_W)
) (
  input  logic [VECT_W-1:0] vect_i,
  output logic [IDX_W-1:0]  idx_c,
  output logic              one_hot_c
);

  // Later loop iterations win, so the loop runs toward the preferred end.
  always_comb begin
    idx_c = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(VECT_W); i++) begin
        if (vect_i[i]) idx_c = IDX_W'(i);
      end
    end else begin
      for (int i = int'(VECT_W) - 1; i >= 0; i--) begin
        if (vect_i[i]) idx_c = IDX_W'(i);
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign one_hot_c = (vect_i != '0) && ((vect_i & (vect_i - VECT_W'(1))) == '0);

endmodule

// File: rtl/bit_scan_encoder.sv
// Bit-scan encoder: accepts a vector and streams out the index of every set
// bit, one beat per bit, with a single "empty" beat for an all-zero vector.
module bit_scan_encoder
  import bit_scan_pkg::*;
#(
  parameter int unsigned  VECT_W    = 8,
  parameter bit           MSB_FIRST = 1'b1,
  localparam int unsigned IDX_W     = $clog2(VECT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VECT_W-1:0] in_vect,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              out_empty
);

  bs_state_e         state_q, state_d;
  logic [VECT_W-1:0] work_q, work_d;
  logic              out_valid_q, out_valid_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              out_empty_q, out_empty_d;

  logic              out_hs_c;
  logic              accept_c;
  logic [IDX_W-1:0]  nxt_idx_c;
  logic              nxt_one_hot_c;

  // Handshakes; a new vector may enter while the final beat of the old one leaves.
  assign out_hs_c = out_valid_q & out_ready;
  assign in_ready = (state_q == IDLE) | (out_hs_c & out_last_q);
  assign accept_c = in_valid & in_ready;

  // Encode the next work value so the beat outputs can be registered.
  prio_enc #(
    .VECT_W   (VECT_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_prio_enc (
    .vect_i   (work_d),
    .idx_c    (nxt_idx_c),
    .one_hot_c(nxt_one_hot_c)
  );

  // Next state, next work vector and next beat outputs.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    out_valid_d = 1'b0;
    out_idx_d   = '0;
    out_last_d  = 1'b0;
    out_empty_d = 1'b0;

    case (state_q)
      SCAN: begin
        if (out_hs_c) begin
          work_d = work_q & ~(VECT_W'(1) << out_idx_q);
          if (out_last_q) state_d = IDLE;
        end
      end
      ZERO: begin
        if (out_hs_c) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept_c) begin
      work_d  = in_vect;
      state_d = (in_vect != '0) ? SCAN : ZERO;
    end

    case (state_d)
      SCAN: begin
        out_valid_d = 1'b1;
        out_idx_d   = nxt_idx_c;
        out_last_d  = nxt_one_hot_c;
      end
      ZERO: begin
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        out_empty_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, work vector and beat output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_empty_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_empty_q <= out_empty_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_empty = out_empty_q;

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Bench for bit_scan_encoder: three instances (8-bit MSB-first, 8-bit
// LSB-first, 5-bit MSB-first), directed scenarios plus random traffic
// checked against a queue-of-beats reference model.
`timescale 1ns/1ps
module tb_bit_scan_encoder;

  localparam int NI = 3;

  logic       clk;
  logic       rst_n;
  logic       iv   [NI];
  logic       ordy [NI];
  logic [7:0] ivec [NI];
  logic       ir   [NI];
  logic       ov   [NI];
  logic       ol   [NI];
  logic       oe   [NI];
  logic [2:0] oidx [NI];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    bit empty;
  } beat_t;

  beat_t mq[$];

  bit_scan_encoder #(.VECT_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_vect(ivec[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_idx(oidx[0]), .out_last(ol[0]),
    .out_empty(oe[0]));

  bit_scan_encoder #(.VECT_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_vect(ivec[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_idx(oidx[1]), .out_last(ol[1]),
    .out_empty(oe[1]));

  bit_scan_encoder #(.VECT_W(5), .MSB_FIRST(1'b1)) u_w5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_vect(ivec[2][4:0]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_idx(oidx[2]), .out_last(ol[2]),
    .out_empty(oe[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int w_of(input int s);
    return (s == 2) ? 5 : 8;
  endfunction

  function automatic bit msb_of(input int s);
    return (s != 1);
  endfunction

  // Observed tuple {valid, in_ready, idx, last, empty}.
  function automatic logic [6:0] tup(input int s);
    return {ov[s], ir[s], oidx[s], ol[s], oe[s]};
  endfunction

  // Model: a vector becomes the list of its set-bit indices in scan order.
  task automatic load_model(input logic [7:0] v, input int s);
    beat_t b;
    int w = w_of(s);
    mq.delete();
    for (int k = 0; k < w; k++) begin
      int i = msb_of(s) ? (w - 1 - k) : k;
      if (v[i]) begin
        b.idx = i; b.empty = 1'b0; mq.push_back(b);
      end
    end
    if (mq.size() == 0) begin
      b.idx = 0; b.empty = 1'b1; mq.push_back(b);
    end
  endtask

  // Model expectation for the current cycle given out_ready r.
  function automatic logic [6:0] exp_tuple(input bit r);
    int n = mq.size();
    logic [2:0] idx = 3'd0;
    bit e = 1'b0;
    if (n != 0) begin
      idx = 3'(mq[0].idx);
      e = mq[0].empty;
    end
    return {(n != 0), ((n == 0) || (n == 1 && r)), idx, (n == 1), e};
  endfunction

  task automatic drive(input int s, input bit v, input logic [7:0] vec, input bit r);
    iv[s] = v; ivec[s] = vec; ordy[s] = r;
    #1;
  endtask

  // Advance one clock and update the model with what the bench drove.
  task automatic tick(input int s);
    bit hs, acc;
    int n = mq.size();
    logic [7:0] v = ivec[s];
    hs  = (n != 0) && ordy[s];
    acc = iv[s] && ((n == 0) || (n == 1 && ordy[s]));
    @(posedge clk);
    #1;
    if (hs) void'(mq.pop_front());
    if (acc) load_model(v, s);
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    for (int s = 0; s < NI; s++) begin
      iv[s] = 1'b0; ivec[s] = 8'h00; ordy[s] = 1'b0;
    end
    rst_n = 1'b0;
    #2;
    for (int s = 0; s < NI; s++) begin
      obs = tup(s);
      checks++;
      if (obs !== 7'b0100000) begin
        errors++;
        $display("FAIL reset inst%0d: got %b want %b", s, obs, 7'b0100000);
      end
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mq.delete();
  endtask

  task automatic test_a5();
    int exp_idx [4] = '{7, 5, 2, 0};
    logic [6:0] obs, exp;
    drive(0, 1'b1, 8'hA5, 1'b1);
    obs = tup(0);
    checks++;
    if (obs !== 7'b0100000) begin
      errors++; $display("FAIL a5_accept: got %b want %b", obs, 7'b0100000);
    end
    tick(0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b0, 8'h00, 1'b1);
      obs = tup(0);
      exp = {1'b1, (k == 3), 3'(exp_idx[k]), (k == 3), 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL a5_beat%0d: got %b want %b", k, obs, exp);
      end
      tick(0);
    end
    drive(0, 1'b0, 8'h00, 1'b1);
    obs = tup(0);
    checks++;
    if (obs !== 7'b0100000) begin
      errors++; $display("FAIL a5_idle: got %b want %b", obs, 7'b0100000);
    end
  endtask

  task automatic test_zero();
    logic [6:0] obs;
    drive(0, 1'b1, 8'h00, 1'b1);
    tick(0);
    drive(0, 1'b0, 8'h00, 1'b1);
    obs = tup(0);
    checks++;
    if (obs !== 7'b1100011) begin
      errors++; $display("FAIL zero_beat: got %b want %b", obs, 7'b1100011);
    end
    tick(0);
    drive(0, 1'b0, 8'h00, 1'b1);
    obs = tup(0);
    checks++;
    if (obs !== 7'b0100000) begin
      errors++; $display("FAIL zero_idle: got %b want %b", obs, 7'b0100000);
    end
  endtask

  task automatic test_stall();
    logic [6:0] obs, exp;
    drive(0, 1'b1, 8'h81, 1'b0);
    tick(0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b0, 8'h00, (k >= 3));
      obs = tup(0);
      if (k < 4) exp = 7'b1011100;
      else exp = 7'b1100010;
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL stall_cyc%0d: got %b want %b", k, obs, exp);
      end
      tick(0);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] obs;
    logic [6:0] exp [5] = '{7'b0100000, 7'b1000100, 7'b1101010, 7'b1100010, 7'b0100000};
    logic [7:0] vec [5] = '{8'h06, 8'h01, 8'h01, 8'h00, 8'h00};
    for (int k = 0; k < 5; k++) begin
      drive(1, (k < 3), vec[k], 1'b1);
      obs = tup(1);
      checks++;
      if (obs !== exp[k]) begin
        errors++; $display("FAIL b2b_cyc%0d: got %b want %b", k, obs, exp[k]);
      end
      tick(1);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [6:0] obs;
    drive(0, 1'b1, 8'hFF, 1'b1);
    tick(0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b0, 8'h00, 1'b1);
      tick(0);
    end
    drive(0, 1'b0, 8'h00, 1'b1);
    obs = tup(0);
    checks++;
    if (obs !== 7'b1010000) begin
      errors++; $display("FAIL rst_pre: got %b want %b", obs, 7'b1010000);
    end
    rst_n = 1'b0;
    #1;
    obs = tup(0);
    checks++;
    if (obs !== 7'b0100000) begin
      errors++; $display("FAIL rst_async: got %b want %b", obs, 7'b0100000);
    end
    mq.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b0, 8'h00, 1'b1);
      obs = tup(0);
      checks++;
      if (obs !== 7'b0100000) begin
        errors++; $display("FAIL rst_after%0d: got %b want %b", k, obs, 7'b0100000);
      end
      tick(0);
    end
  endtask

  task automatic test_width5();
    logic [6:0] obs, exp;
    drive(2, 1'b1, 8'h1F, 1'b1);
    tick(2);
    for (int k = 0; k < 6; k++) begin
      drive(2, 1'b0, 8'h00, 1'b1);
      obs = tup(2);
      if (k < 5) exp = {1'b1, (k == 4), 3'(4 - k), (k == 4), 1'b0};
      else exp = 7'b0100000;
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL w5_beat%0d: got %b want %b", k, obs, exp);
      end
      tick(2);
    end
  endtask

  task automatic test_random();
    logic [6:0] obs, exp;
    logic [7:0] vec;
    bit v, r;
    int guard;
    for (int s = 0; s < NI; s++) begin
      mq.delete();
      for (int c = 0; c < 300; c++) begin
        v = ($urandom_range(0, 1) == 1);
        r = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 3))
          0:       vec = 8'h00;
          1:       vec = 8'(1 << $urandom_range(0, 7));
          default: vec = 8'($urandom);
        endcase
        drive(s, v, vec, r);
        obs = tup(s);
        exp = exp_tuple(r);
        checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL rand inst%0d cyc%0d: got %b want %b", s, c, obs, exp);
        end
        tick(s);
      end
      guard = 0;
      while (mq.size() != 0 && guard < 20) begin
        drive(s, 1'b0, 8'h00, 1'b1);
        tick(s);
        guard++;
      end
      drive(s, 1'b0, 8'h00, 1'b1);
      obs = tup(s);
      checks++;
      if (obs !== 7'b0100000) begin
        errors++; $display("FAIL rand_drain inst%0d: got %b want %b", s, obs, 7'b0100000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_zero();
    test_stall();
    test_back_to_back();
    test_reset_mid_scan();
    test_width5();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_scan_encoder.md
BIT_SCAN_ENCODER -- requirements
Module: bit_scan_encoder

Interface
REQ-001 SHALL have parameter VECT_W, default 8, input vector width (>= 2).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = scan highest set bit first, 0 = lowest first.
REQ-003 SHALL have localparam IDX_W = $clog2(VECT_W), the index width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  in_vect valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a vector this cycle.
REQ-008 SHALL have port in_vect  input  VECT_W  vector to scan.
REQ-009 SHALL have port out_valid  output  1  out_idx/out_last/out_empty valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the current beat.
REQ-011 SHALL have port out_idx  output  IDX_W  bit index of the current set bit.
REQ-012 SHALL have port out_last  output  1  final beat for this vector.
REQ-013 SHALL have port out_empty  output  1  accepted vector was all-zero.

Function
REQ-014 SHALL emit one output beat per set bit of each accepted vector, in scan order set by MSB_FIRST.
REQ-015 SHALL have states IDLE (no vector held), SCAN (non-zero work vector held) and ZERO (all-zero vector held).
REQ-016 SHALL accept a vector on in_valid & in_ready and load it into the work register at that edge.
REQ-017 SHALL enter SCAN after acceptance if in_vect != 0, otherwise ZERO.
REQ-018 SHALL assert in_ready = (state == IDLE) | (out_valid & out_ready & out_last).
REQ-019 SHALL present the first beat of an accepted vector on out_valid in the cycle after acceptance (latency 1).
REQ-020 SHALL in SCAN drive out_valid = 1, out_idx = priority-encoded index of the work register, out_last = 1 iff exactly one work bit is set, out_empty = 0.
REQ-021 SHALL in ZERO drive out_valid = 1, out_idx = 0, out_last = 1, out_empty = 1.
REQ-022 SHALL on out_valid & out_ready in SCAN clear the bit at out_idx in the work register.
REQ-023 SHALL on a handshake of a beat with out_last = 1 go to IDLE, unless a new vector is accepted in the same cycle, in which case it goes to SCAN or ZERO per REQ-017.
REQ-024 SHALL keep out_idx, out_last, out_empty and the work register stable while out_valid & !out_ready.
REQ-025 SHALL ignore in_vect whenever in_ready = 0; the work register is never modified by input.
REQ-026 SHALL drive out_valid = 0 in IDLE, with out_idx, out_last and out_empty all 0.
REQ-027 SHALL for a vector with all VECT_W bits set produce VECT_W beats, the last one at index 0 (MSB_FIRST = 1) or VECT_W-1 (MSB_FIRST = 0).

Reset
REQ-028 SHALL, while rst_n = 0, asynchronously force state = IDLE, work register = 0, out_valid = 0, out_idx = 0, out_last = 0 and out_empty = 0; in_ready is 1 during reset.
REQ-029 SHALL, on reset mid-scan, drop the remaining beats of the in-flight vector, with nothing emitted after rst_n rises until a new vector is accepted.

Structure
REQ-030 SHALL place the state enum (IDLE/SCAN/ZERO) and an idx_width(VECT_W) function in package bit_scan_pkg.
REQ-031 SHALL implement priority selection in a combinational sub-module prio_enc (parameters VECT_W, MSB_FIRST; outputs index and a one-hot-remaining flag).
REQ-032 SHALL keep the FSM and the work register in bit_scan_encoder only.

Verification
REQ-033 SHALL cover: VECT_W=8, MSB_FIRST=1, out_ready=1, accept 0xA5 -> beats idx 7,5,2,0 on consecutive cycles, last only on idx 0, first beat 1 cycle after accept.
REQ-034 SHALL cover: accept 0x00 -> one beat idx 0, out_last=1, out_empty=1, then IDLE.
REQ-035 SHALL cover: accept 0x81 with out_ready low for 3 cycles -> idx 7 held stable 4 cycles, then idx 0 last.
REQ-036 SHALL cover: MSB_FIRST=0, in_valid held with 0x06 then 0x01 -> beats 1,2(last); 0x01 is accepted in the cycle of the idx-2 handshake; next cycle idx 0 last; no bubble.
REQ-037 SHALL cover: accept 0xFF, assert rst_n=0 after 3 beats -> out_valid=0 immediately, in_ready=1; after release, no beats until the next accept.
REQ-038 SHALL cover: VECT_W=5, accept 0x1F -> 5 beats idx 4..0, out_idx width 3.
